// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled frame decoder with a small receive FIFO.
// Serial line is synchronized, decoded LSB-first, and complete frames are pushed into the FIFO.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line idle, waiting for synchronized rx to go low
//   START | counting to the middle of the start bit, rejecting glitches
//   DATA  | sampling DBIT data bits at their midpoints, LSB first
//   STOP  | waiting SB_TICK ticks, then push (rx=1) or flag frame error (rx=0)
module uart_rx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd_en,
    output logic [DBIT-1:0] rx_data,
    output logic            empty,
    output logic            full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int              BW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int              AW        = $clog2(DEPTH);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DBIT - 1);
    localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            rx_meta, rx_sync;
    logic            push, stop_bad;

    logic [AW:0]     wr_ptr, rd_ptr;
    logic [DBIT-1:0] mem [DEPTH];
    logic            do_rd, do_wr;

    // Synchronizer flops reset to the idle (high) line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == 4'd7) begin
                        if (!rx_sync) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == 4'd15) begin
                        tick_d  = '0;
                        shift_d = {rx_sync, shift_q[DBIT-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        state_d = IDLE;
                        if (rx_sync) begin
                            push = 1'b1;
                        end else begin
                            stop_bad = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = push && (!full || do_rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= shift_q;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign rx_data = mem[rd_ptr[AW-1:0]];

    // Status pulses are registered; push and stop_bad are exclusive, so the two never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= push && full && !rd_en;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames at 16 ticks/bit, FIFO fill/drain, errors and reset abort.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int fe_snap;
    int ov_snap;

    uart_rx_fifo #(.DBIT(8), .SB_TICK(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .s_tick    (s_tick),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 8 clocks, updated just after the rising edge.
    initial begin
        int tcnt;
        tcnt   = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (tcnt == 7);
            tcnt   = (tcnt + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (s_tick) k++;
        end
        @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Full frame: start, 8 data bits LSB first, stop; optional pop aligned to the push edge.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit pop_at_push);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
        if (!stop_ok) begin
            rx = 1'b0;
            wait_ticks(10);
            rx = 1'b1;
            wait_ticks(6);
        end else if (pop_at_push) begin
            rx = 1'b1;
            wait_ticks(7);
            do @(negedge clk); while (!s_tick);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            wait_ticks(8);
        end else begin
            rx = 1'b1;
            wait_ticks(16);
        end
        wait_ticks(4);
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_empty", empty, 1'b1);
        check("reset_full", full, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        reset = 1'b1;
        wait_ticks(4);

        // Clean 0xA5 frame
        fe_snap = fe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_empty", empty, 1'b0);
        check("a5_data", rx_data, 8'hA5);
        check("a5_full", full, 1'b0);
        check("a5_no_frame_err", fe_cnt - fe_snap, 0);
        pop();
        check("a5_drained", empty, 1'b1);

        // Short low glitch is rejected
        fe_snap = fe_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(12);
        check("glitch_empty", empty, 1'b1);
        check("glitch_no_frame_err", fe_cnt - fe_snap, 0);

        // 0x3C with low stop bit
        fe_snap = fe_cnt;
        ov_snap = ov_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("ferr_pulse_width", fe_cnt - fe_snap, 1);
        check("ferr_empty", empty, 1'b1);
        check("ferr_no_overrun", ov_cnt - ov_snap, 0);

        // Fill to full, then overrun on the fifth frame
        ov_snap = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
        end
        check("fill_full", full, 1'b1);
        check("fill_head", rx_data, 8'h01);
        check("fill_no_overrun", ov_cnt - ov_snap, 0);
        send_frame(8'h05, 1'b1, 1'b0);
        check("overrun_pulse", ov_cnt - ov_snap, 1);
        check("overrun_full", full, 1'b1);
        check("overrun_head", rx_data, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), rx_data, 8'(i));
            pop();
        end
        check("drain_empty", empty, 1'b1);
        check("drain_not_full", full, 1'b0);
        pop();
        check("pop_empty_ignored", empty, 1'b1);

        // Push and pop together while full
        ov_snap = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        check("pp_full_before", full, 1'b1);
        send_frame(8'h77, 1'b1, 1'b1);
        check("pp_no_overrun", ov_cnt - ov_snap, 0);
        check("pp_full_after", full, 1'b1);
        check("pp_head", rx_data, 8'h22);
        pop();
        check("pp_second", rx_data, 8'h33);
        pop();
        check("pp_third", rx_data, 8'h44);
        pop();
        check("pp_last", rx_data, 8'h77);
        pop();
        check("pp_empty", empty, 1'b1);

        // Reset in DATA bit 3 of 0xFF, then 0x5A with a pop attempted in its push cycle while empty
        fe_snap = fe_cnt;
        ov_snap = ov_cnt;
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(16 * 3 + 4);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_empty", empty, 1'b1);
        check("midrst_rx_data", rx_data, 8'h00);
        reset = 1'b1;
        wait_ticks(20);
        check("midrst_no_push", empty, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("after_rst_empty", empty, 1'b0);
        check("after_rst_data", rx_data, 8'h5A);
        pop();
        check("after_rst_single", empty, 1'b1);
        check("midrst_no_frame_err", fe_cnt - fe_snap, 0);
        check("midrst_no_overrun", ov_cnt - ov_snap, 0);
        check("pulses_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL take parameter DBIT, default 8, as the number of data bits per frame.
REQ-002 The block SHALL take parameter SB_TICK, default 16, as the number of s_tick periods in the stop bit.
REQ-003 The block SHALL take parameter DEPTH, default 4 (power of 2), as the number of receive FIFO entries.
REQ-004 clk  input  1  Single clock; all state on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-low reset (asserted when 0).
REQ-006 rx  input  1  Asynchronous serial line; idle high.
REQ-007 s_tick  input  1  One-clk pulse at 16x baud rate, from the baud generator.
REQ-008 rd_en  input  1  Pop request for the FIFO head.
REQ-009 rx_data  output  DBIT  FIFO head byte, valid while empty=0.
REQ-010 empty  output  1  FIFO holds no bytes.
REQ-011 full  output  1  FIFO holds DEPTH bytes; drives the baud generator's full input.
REQ-012 frame_err  output  1  One-clk pulse: stop bit sampled low.
REQ-013 overrun  output  1  One-clk pulse: byte completed while FIFO full and no pop that cycle; byte dropped.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (2-clk latency).
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; the tick counter is 4 bits wide and the bit counter is log2(DBIT) bits wide.
REQ-016 IDLE: on synchronized rx=0, the FSM SHALL go to START and clear the tick counter; s_tick is not required for this transition.
REQ-017 START: on the s_tick where the tick counter equals 7, the FSM SHALL go to DATA with both counters cleared if rx=0, else return to IDLE (glitch reject); other s_ticks SHALL increment the tick counter.
REQ-018 DATA: on the s_tick where the tick counter equals 15, the block SHALL shift rx into the MSB of the shift register (LSB-first frame) and clear the tick counter; after bit DBIT-1 the FSM SHALL go to STOP, else increment the bit counter.
REQ-019 STOP: on the s_tick where the tick counter equals SB_TICK-1, the FSM SHALL sample rx and return to IDLE; rx=1 produces a push of the shift register, rx=0 produces a frame_err pulse and no push.
REQ-020 Counters SHALL advance only on s_tick; clk cycles without s_tick SHALL hold all FSM state.
REQ-021 A push SHALL write the FIFO in the same cycle the FSM leaves STOP; empty SHALL fall on the next cycle.
REQ-022 rd_en with empty=0 SHALL advance the read pointer; rx_data SHALL show the next entry on the next cycle.
REQ-023 rd_en with empty=1 SHALL be ignored.
REQ-024 Push while full=1 without rd_en SHALL drop the byte and pulse overrun; FIFO contents SHALL be unchanged.
REQ-025 Push and rd_en in the same cycle while full=1 SHALL perform both; occupancy stays DEPTH; no overrun.
REQ-026 Push and rd_en in the same cycle while empty=1 SHALL perform the push only.
REQ-027 Pointers SHALL be log2(DEPTH)+1 bits; wrap-around SHALL be by natural overflow; full and empty SHALL be decoded from the pointers.
REQ-028 frame_err and overrun SHALL be mutually exclusive in any cycle.

Reset
REQ-029 While reset=0: FSM=IDLE, all counters and pointers 0, shift register 0, both synchronizer flops 1.
REQ-030 While reset=0: empty=1, full=0, frame_err=0, overrun=0, rx_data=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no push and no pulses; after release, reception SHALL resume on the next falling edge of rx.

Verification
REQ-032 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 s_tick/bit -> one push, rx_data=0xA5, empty=0, frame_err=0.
REQ-033 rx low for 4 s_ticks, then high -> FSM back in IDLE, no push, no frame_err.
REQ-034 Frame 0x3C with stop bit low -> frame_err for exactly 1 clk, empty stays 1.
REQ-035 Five frames 0x01..0x05 with no reads -> full=1 after the 4th frame, overrun for 1 clk on the 5th; reads then return 0x01..0x04 and empty=1.
REQ-036 FIFO full, rd_en asserted in the push cycle of 0x77 -> no overrun, full stays 1, the last entry read is 0x77.
REQ-037 reset=0 during DATA bit 3 of 0xFF, then a clean 0x5A -> only 0x5A is received.
